matmult_sequencer: RTL and testbench
====================================

Name: matmult_sequencer

Overview:
- Control stage directly upstream of the 4x4 16-bit matrix multiplier.
- On a start command, fetches operand matrices A and B from a 256-bit-wide memory and loads them into the multiplier: A with mat-decide 0, B with mat-decide 1.
- Then reads back the product and writes it to a destination address.
- Provides busy, done and error status to the host, and includes a timeout watchdog on every handshake.

Parameters:
- ADDR_W, 16, width of memory word addresses.
- TIMEOUT, 64, maximum cycles to wait for any ack/fleg before aborting; must be at least 2.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle job request; sampled only in IDLE.
- src_a_addr  input  ADDR_W  memory address of matrix A; latched on accepted start.
- src_b_addr  input  ADDR_W  memory address of matrix B; latched on accepted start.
- dst_addr  input  ADDR_W  memory address for the product; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  one-cycle pulse on job completion or abort.
- error  output  1  set on timeout abort; held until the next accepted start.
- mem_en  output  1  memory request strobe.
- mem_rw  output  1  1 = write, 0 = read.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  256  write data.
- mem_rdata  input  256  read data, valid while mem_ack is high.
- mem_ack  input  1  memory completion pulse.
- mm_enable  output  1  multiplier enable strobe.
- mm_rw  output  1  1 = load matrix into multiplier, 0 = read result.
- mm_mat_decide  output  1  0 = matrix A, 1 = matrix B.
- mm_data_in  output  256  matrix to the multiplier; element [i][j] at bits i*64+16*j +:16.
- mm_data_out  input  256  product from the multiplier, valid while mm_fleg is high.
- mm_fleg  input  1  multiplier completion pulse.

Behaviour:
- Reset values: every output 0; state IDLE; operand buffer 0; timeout counter 0.
- Reset mid-job aborts immediately. No done pulse and no error are produced.
- States and transitions:
  - IDLE: start=1 latches the three addresses, clears error and goes to RD_A.
  - RD_A: memory read at src_a_addr; on mem_ack capture mem_rdata into buffer, go to LD_A.
  - LD_A: mm_rw=1, mm_mat_decide=0, mm_data_in=buffer; on mm_fleg go to RD_B.
  - RD_B: memory read at src_b_addr; on mem_ack capture mem_rdata, go to LD_B.
  - LD_B: mm_rw=1, mm_mat_decide=1, mm_data_in=buffer; on mm_fleg go to RD_RES.
  - RD_RES: mm_rw=0; on mm_fleg capture mm_data_out into buffer, go to WR_RES.
  - WR_RES: memory write, mem_addr=dst_addr, mem_wdata=buffer; on mem_ack go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Strobe rule:
  - mem_en / mm_enable are high for exactly the first cycle of each request state, then low while waiting.
  - Address, rw, mat_decide and data outputs stay stable for the whole state.
- An ack or fleg in the same cycle as its strobe is ignored; the earliest accepted response is the cycle after the strobe.
- Acks arriving in a state that does not expect them are ignored, e.g. mem_ack during LD_x or mm_fleg during RD_x.
- Timeout:
  - The counter clears on every state entry and increments each waiting cycle.
  - If it reaches TIMEOUT without a response: error=1, done=1 for one cycle, go to IDLE, all strobes low.
- start while busy is ignored and does not re-latch addresses. start during FIN is ignored.
- busy: 0 in IDLE, 1 in all other states including FIN.
- Back-to-back operation: a start in the cycle after FIN is accepted.
- Minimum job latency with single-cycle acks: 6 response cycles plus 6 strobe cycles plus FIN, i.e. done 13 cycles after the start edge.
- No arithmetic is performed in this block; data passes through unmodified, with bit positions preserved.

Test Plan:
- Normal job: A=identity at 0x0010, B elements 1..16 at 0x0020, dst 0x0030, bench models with single-cycle acks.
  - Required: memory word 0x0030 equals B; done pulses exactly 13 cycles after start; error=0.
- Arithmetic pass-through: A all 2, B all 3, multiplier model computes mod 2^16.
  - Required: every 16-bit field at dst is 24 (0x0018).
  - Rerun with A all 0x4000, B all 4: every field is 0x0000 (wrap preserved).
- Timeout: memory never acks RD_B, TIMEOUT=64.
  - Required: done and error pulse 64 cycles after the RD_B strobe; no mm_enable with mat_decide=1; busy=0 next cycle.
  - A subsequent normal job clears error.
- start while busy: second start with different addresses during LD_A.
  - Required: it is ignored; the write still goes to the first dst_addr; exactly one done.
- Reset mid-job: assert reset in RD_RES.
  - Required: next cycle all outputs 0 and state IDLE; no memory write; a fresh job then completes normally.
- Early and stray acks: mem_ack coincident with the RD_A strobe, and mm_fleg during RD_B.
  - Required: both are ignored; the job waits for a valid mem_ack on the following cycle; the result is correct.

Source files
------------

// File: rtl/matmult_sequencer.sv
// matmult_sequencer: fetches A and B, loads the 4x4 multiplier, reads the
// product back and writes it to dst. Host: start/addrs/busy/done/error.
// Memory: mem_en/rw/addr/wdata, mem_rdata/ack. Multiplier: mm_*, mm_fleg.
module matmult_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a_addr,
  input  logic [ADDR_W-1:0] src_b_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [255:0]      mem_wdata,
  input  logic [255:0]      mem_rdata,
  input  logic              mem_ack,
  output logic              mm_enable,
  output logic              mm_rw,
  output logic              mm_mat_decide,
  output logic [255:0]      mm_data_in,
  input  logic [255:0]      mm_data_out,
  input  logic              mm_fleg
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_LD_A, S_RD_B,
    S_LD_B, S_RD_RES, S_WR_RES, S_FIN
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [255:0]      buf_q, buf_d;
  logic [ADDR_W-1:0] a_q, a_d, b_q, b_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [255:0]      mem_wdata_q, mem_wdata_d;
  logic              mm_en_q, mm_en_d;
  logic              mm_rw_q, mm_rw_d;
  logic              mm_md_q, mm_md_d;
  logic [255:0]      mm_din_q, mm_din_d;

  logic mem_ok, mm_ok, wait_st, enter;

  // A response coincident with its strobe is not accepted.
  assign mem_ok  = mem_ack & ~mem_en_q;
  assign mm_ok   = mm_fleg & ~mm_en_q;
  assign wait_st = state_q inside {S_RD_A, S_LD_A, S_RD_B,
                                   S_LD_B, S_RD_RES, S_WR_RES};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    a_d     = a_q;
    b_d     = b_q;
    dst_d   = dst_q;
    error_d = error_q;

    unique case (state_q)
      S_IDLE: if (start) begin
        a_d     = src_a_addr;
        b_d     = src_b_addr;
        dst_d   = dst_addr;
        error_d = 1'b0;
        state_d = S_RD_A;
      end
      S_RD_A: if (mem_ok) begin
        buf_d   = mem_rdata;
        state_d = S_LD_A;
      end
      S_LD_A: if (mm_ok) state_d = S_RD_B;
      S_RD_B: if (mem_ok) begin
        buf_d   = mem_rdata;
        state_d = S_LD_B;
      end
      S_LD_B: if (mm_ok) state_d = S_RD_RES;
      S_RD_RES: if (mm_ok) begin
        buf_d   = mm_data_out;
        state_d = S_WR_RES;
      end
      S_WR_RES: if (mem_ok) state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Watchdog: the strobe cycle counts as the first waiting cycle.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_st) begin
      if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = S_FIN;
        error_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Outputs follow the next state so they are registered and stable.
  always_comb begin
    enter       = state_d != state_q;
    busy_d      = state_d != S_IDLE;
    done_d      = enter && state_d == S_FIN;
    mem_en_d    = enter &&
                  (state_d inside {S_RD_A, S_RD_B, S_WR_RES});
    mm_en_d     = enter &&
                  (state_d inside {S_LD_A, S_LD_B, S_RD_RES});
    mem_rw_d    = state_d == S_WR_RES;
    mm_rw_d     = state_d inside {S_LD_A, S_LD_B};
    mm_md_d     = state_d == S_LD_B;
    mem_wdata_d = mem_rw_d ? buf_d : '0;
    mm_din_d    = mm_rw_d ? buf_d : '0;
    mem_addr_d  = '0;
    unique case (1'b1)
      state_d == S_RD_A:   mem_addr_d = a_d;
      state_d == S_RD_B:   mem_addr_d = b_d;
      state_d == S_WR_RES: mem_addr_d = dst_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      dst_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mm_en_q     <= 1'b0;
      mm_rw_q     <= 1'b0;
      mm_md_q     <= 1'b0;
      mm_din_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dst_q       <= dst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mm_en_q     <= mm_en_d;
      mm_rw_q     <= mm_rw_d;
      mm_md_q     <= mm_md_d;
      mm_din_q    <= mm_din_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign mem_en        = mem_en_q;
  assign mem_rw        = mem_rw_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mm_enable     = mm_en_q;
  assign mm_rw         = mm_rw_q;
  assign mm_mat_decide = mm_md_q;
  assign mm_data_in    = mm_din_q;

endmodule

// File: tb/tb_matmult_sequencer.sv
// tb_matmult_sequencer: memory and multiplier models with configurable
// ack delay, dropped acks, early and stray acks; directed + random jobs.
module tb_matmult_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  src_a_addr = '0;
  logic [15:0]  src_b_addr = '0;
  logic [15:0]  dst_addr = '0;
  logic         busy, done, error;
  logic         mem_en, mem_rw;
  logic [15:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic         mm_enable, mm_rw, mm_mat_decide;
  logic [255:0] mm_data_in;
  logic [255:0] mm_data_out = '0;
  logic         mm_fleg = 1'b0;

  always #5 clk = ~clk;

  matmult_sequencer #(.ADDR_W(16), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
    .dst_addr(dst_addr), .busy(busy), .done(done),
    .error(error), .mem_en(mem_en), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mm_enable(mm_enable), .mm_rw(mm_rw),
    .mm_mat_decide(mm_mat_decide), .mm_data_in(mm_data_in),
    .mm_data_out(mm_data_out), .mm_fleg(mm_fleg)
  );

  localparam logic [255:0] GARBAGE = {8{32'hDEADBEEF}};

  int n_cmp = 0;
  int n_err = 0;

  logic [255:0] mem [logic [15:0]];
  int   mem_dly = 1;
  int   mm_dly = 1;
  bit   no_ack_en = 0;
  bit   early_ack = 0;
  bit   stray_fleg = 0;
  logic [15:0] no_ack_addr = '0;
  logic [15:0] early_addr = '0;
  logic [15:0] stray_addr = '0;
  int   mcnt = 0;
  int   xcnt = 0;
  int   wr_cnt = 0;
  int   ldb_cnt = 0;
  logic [15:0]  wr_addr = '0;
  logic [15:0]  m_addr = '0;
  logic         m_wr = 1'b0;
  logic [255:0] m_wd = '0;
  logic [255:0] m_rd = '0;
  logic [255:0] ma = '0;
  logic [255:0] mb = '0;
  logic [255:0] x_out = '0;

  function automatic logic [255:0] matmul(
    input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    logic [15:0]  s;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = '0;
        for (int k = 0; k < 4; k++)
          s = s + a[i*64+16*k +: 16] * b[k*64+16*j +: 16];
        r[i*64+16*j +: 16] = s;
      end
    return r;
  endfunction

  function automatic logic [255:0] mem_rd(input logic [15:0] ad);
    if (mem.exists(ad)) return mem[ad];
    return '0;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Memory and multiplier models, driven on the falling edge.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    mm_fleg = 1'b0;
    if (reset) begin
      mcnt = 0;
      xcnt = 0;
    end else begin
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = m_rd;
          if (m_wr) begin
            mem[m_addr] = m_wd;
            wr_cnt++;
            wr_addr = m_addr;
          end
        end
      end
      if (xcnt > 0) begin
        xcnt--;
        if (xcnt == 0) begin
          mm_fleg = 1'b1;
          mm_data_out = x_out;
        end
      end
      if (mem_en) begin
        m_addr = mem_addr;
        m_wr = mem_rw;
        m_wd = mem_wdata;
        m_rd = mem_rd(mem_addr);
        if (!(no_ack_en && !mem_rw && mem_addr == no_ack_addr))
          mcnt = mem_dly;
        if (early_ack && !mem_rw && mem_addr == early_addr) begin
          mem_ack = 1'b1;
          mem_rdata = GARBAGE;
        end
        if (stray_fleg && !mem_rw && mem_addr == stray_addr) begin
          mm_fleg = 1'b1;
          mm_data_out = GARBAGE;
        end
      end
      if (mm_enable) begin
        if (mm_rw) begin
          if (mm_mat_decide) begin
            mb = mm_data_in;
            ldb_cnt++;
          end else begin
            ma = mm_data_in;
          end
        end else begin
          x_out = matmul(ma, mb);
        end
        xcnt = mm_dly;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"},
        {busy, done, error, mem_en, mem_rw,
         mm_enable, mm_rw, mm_mat_decide}, '0);
    chk({tag, "_addr"}, mem_addr, '0);
    chk({tag, "_wdata"}, mem_wdata, '0);
    chk({tag, "_mmin"}, mm_data_in, '0);
  endtask

  task automatic run_job(input logic [15:0] a,
                         input logic [15:0] b,
                         input logic [15:0] d,
                         input bit exp_to,
                         input bit busy_start);
    int cyc, rdb, wr0, ldb0, lat_exp, extra;
    logic [255:0] exp_w;
    wr0 = wr_cnt;
    ldb0 = ldb_cnt;
    mem.delete(d);
    lat_exp = 6 * mem_dly / 2 + 6 * mm_dly / 2 + 6 + 1;
    lat_exp = 3 * mem_dly + 3 * mm_dly + 6 + 1;
    exp_w = matmul(mem_rd(a), mem_rd(b));
    @(posedge clk); #1;
    start = 1'b1;
    src_a_addr = a;
    src_b_addr = b;
    dst_addr = d;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 0;
    rdb = -1;
    while (!done && cyc < 400) begin
      if (mem_en && !mem_rw && mem_addr == b && rdb < 0) rdb = cyc;
      if (busy_start && mm_enable && mm_rw && !mm_mat_decide) begin
        start = 1'b1;
        src_a_addr = 16'h0f00;
        src_b_addr = 16'h0f10;
        dst_addr = 16'h0f20;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("done_seen", done, 1);
    if (exp_to) begin
      chk("timeout_after_rdb_strobe", cyc - rdb, 64);
      chk("error_on_timeout", error, 1);
      chk("no_load_b", ldb_cnt - ldb0, 0);
      chk("no_write_on_timeout", wr_cnt - wr0, 0);
    end else begin
      chk("done_edge_after_start", cyc + 1, lat_exp);
      chk("error_clear", error, 0);
      chk("dst_word", mem_rd(d), exp_w);
      chk("one_write", wr_cnt - wr0, 1);
      chk("write_addr", wr_addr, d);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_back_idle", busy, 0);
    chk("error_held", error, exp_to);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("single_done", extra, 0);
  endtask

  initial begin
    logic [255:0] ident, bmat, all2, all3, big, all4;
    int wr0, found;
    ident = '0;
    bmat = '0;
    for (int i = 0; i < 4; i++) begin
      ident[i*64+16*i +: 16] = 16'd1;
      for (int j = 0; j < 4; j++)
        bmat[i*64+16*j +: 16] = 16'(i * 4 + j + 1);
    end
    all2 = {16{16'd2}};
    all3 = {16{16'd3}};
    big = {16{16'h4000}};
    all4 = {16{16'd4}};

    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    reset = 1'b0;

    mem[16'h0010] = ident;
    mem[16'h0020] = bmat;
    run_job(16'h0010, 16'h0020, 16'h0030, 0, 0);
    chk("identity_gives_b", mem_rd(16'h0030), bmat);

    mem[16'h0040] = all2;
    mem[16'h0050] = all3;
    run_job(16'h0040, 16'h0050, 16'h0060, 0, 0);
    chk("all_24", mem_rd(16'h0060), {16{16'h0018}});

    mem[16'h0070] = big;
    mem[16'h0080] = all4;
    run_job(16'h0070, 16'h0080, 16'h0090, 0, 0);
    chk("wrap_zero", mem_rd(16'h0090), '0);

    no_ack_en = 1;
    no_ack_addr = 16'h0020;
    run_job(16'h0010, 16'h0020, 16'h00a0, 1, 0);
    no_ack_en = 0;
    run_job(16'h0040, 16'h0050, 16'h00b0, 0, 0);

    run_job(16'h0010, 16'h0020, 16'h00c0, 0, 1);
    chk("busy_start_dst_untouched", mem.exists(16'h0f20), 0);

    wr0 = wr_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    src_a_addr = 16'h0040;
    src_b_addr = 16'h0050;
    dst_addr = 16'h00d0;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (mm_enable && !mm_rw) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("reached_rd_res", found, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_idle("mid_reset");
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) found++;
    end
    chk("idle_after_reset", found, 0);
    chk("no_write_after_reset", wr_cnt - wr0, 0);
    run_job(16'h0040, 16'h0050, 16'h00d0, 0, 0);

    early_ack = 1;
    early_addr = 16'h0070;
    stray_fleg = 1;
    stray_addr = 16'h0080;
    run_job(16'h0070, 16'h0080, 16'h00e0, 0, 0);
    early_ack = 0;
    stray_fleg = 0;

    for (int n = 0; n < 6; n++) begin
      logic [15:0] a;
      a = 16'($urandom_range(16'h0100, 16'h3fff));
      mem[a] = rnd256();
      mem[a + 16'h4000] = rnd256();
      mem_dly = $urandom_range(1, 4);
      mm_dly = $urandom_range(1, 4);
      run_job(a, a + 16'h4000, a + 16'h8000, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
